// File: rtl/seg_disp_pkg.sv
//------------------------------------------------------------------------------
// Package  : seg_disp_pkg
// Brief    : Shared types and constants for the 7-segment scan multiplexer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg_disp_pkg;

  // Code the downstream decoder renders with every segment off
  localparam logic [3:0] BCD_DARK   = 4'hF;
  localparam int         MAX_DIGITS = 8;

  typedef enum logic [0:0] {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Active-low anode pattern with the low n bits set (all digits off)
  function automatic logic [MAX_DIGITS-1:0] all_off(input int n);
    logic [MAX_DIGITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_timer.sv
//------------------------------------------------------------------------------
// Module   : seg_scan_timer
// Brief    : Free-running cycle counter with runtime terminal value and
//            synchronous clear; times both lit and guard intervals.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign tc = (r_count == last);

endmodule

`default_nettype wire

// File: rtl/seg_scan_mux.sv
//------------------------------------------------------------------------------
// Module   : seg_scan_mux
// Brief    : Common-anode multi-digit 7-segment scanner with guard interval.
//            Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD_CYC  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic                          blank,
  output logic [3:0]                    bcd,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] dig_idx,
  output logic                          frame_start
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int TW = $clog2((SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC);

  localparam logic [IW-1:0]         c_last_idx   = IW'(NUM_DIGITS - 1);
  localparam logic [MAX_DIGITS-1:0] c_off_wide   = all_off(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] c_an_off     = c_off_wide[NUM_DIGITS-1:0];
  localparam logic [TW-1:0]         c_show_last  = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0]         c_guard_last = TW'(GUARD_CYC - 1);

  scan_state_t             r_state;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [3:0]              r_bcd;
  logic                    r_fs;

  scan_state_t             w_nxt_state;
  logic [IW-1:0]           w_nxt_idx;
  logic [IW-1:0]           w_sel;
  logic                    w_lit;
  logic                    w_nxt_fs;
  logic [NUM_DIGITS-1:0]   w_nxt_an;
  logic [3:0]              w_nxt_bcd;
  logic [NUM_DIGITS-1:0]   w_lzb;
  logic [TW-1:0]           w_last;
  logic                    w_tc;

  assign w_last = (r_state == SHOW) ? c_show_last : c_guard_last;

  // Cleared on its own terminal count, so each interval restarts from zero
  seg_scan_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_tc),
    .last (w_last),
    .tc   (w_tc)
  );

`ifdef SEG_SCAN_LZB_EN
  // Digit k is a leading zero when it and every more significant digit are 0
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lzb
    if (k == 0) begin : g_units
      assign w_lzb[k] = 1'b0;
    end else begin : g_upper
      assign w_lzb[k] = (r_shadow[4*NUM_DIGITS-1:4*k] == '0);
    end
  end
`else
  assign w_lzb = '0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_sel       = r_idx;
    w_lit       = 1'b0;
    w_nxt_fs    = 1'b0;
    unique case (r_state)
      GUARD: begin
        if (w_tc) begin
          w_nxt_state = SHOW;
          w_nxt_idx   = (r_idx == c_last_idx) ? '0 : r_idx + IW'(1);
          w_sel       = w_nxt_idx;
          w_lit       = 1'b1;
          w_nxt_fs    = (w_nxt_idx == '0);
        end
      end
      SHOW: begin
        if (w_tc) begin
          w_nxt_state = GUARD;
        end else begin
          w_lit = 1'b1;
        end
      end
    endcase

    // Output registers follow the state being entered, not the current one
    w_nxt_an  = c_an_off;
    w_nxt_bcd = BCD_DARK;
    if (w_lit && !blank && !w_lzb[w_sel]) begin
      w_nxt_an[w_sel] = 1'b0;
      w_nxt_bcd       = r_shadow[{w_sel, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= GUARD;
      r_idx    <= c_last_idx;
      r_shadow <= '0;
      r_an     <= c_an_off;
      r_bcd    <= BCD_DARK;
      r_fs     <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_an    <= w_nxt_an;
      r_bcd   <= w_nxt_bcd;
      r_fs    <= w_nxt_fs;
      if (load) begin
        r_shadow <= digits_in;
      end
    end
  end

  assign an          = r_an;
  assign bcd         = r_bcd;
  assign dig_idx     = r_idx;
  assign frame_start = r_fs;

endmodule

`default_nettype wire
